// File: rtl/unsigned_div_16by8_seq_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Build option: UNSIGNED_DIV_APPROX_EN selects the truncated-quotient variant.
package unsigned_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    localparam int DW_DEF = 8;
    localparam int L_DEF  = 6;

    typedef struct packed {
        int width;
        int iter;
    } iter_cfg_t;

    function automatic iter_cfg_t iter_count(int dw, int l, bit approx);
        iter_cfg_t c;
        c.iter  = approx ? (2 * dw - l) : (2 * dw);
        c.width = (c.iter > 1) ? $clog2(c.iter) : 1;
        return c;
    endfunction

endpackage

// File: rtl/unsigned_div_16by8_seq_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract,
// keep or restore. Purely combinational.
module div_restore_step
    import unsigned_div_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] i_rem,
    input  logic          i_bit,
    input  logic [DW-1:0] i_divisor,
    output logic [DW-1:0] o_rem,
    output logic          o_qbit
);

    logic [DW:0]   w_shift;
    logic [DW-1:0] w_diff;

    assign w_shift = {i_rem, i_bit};

    // A set top bit means the shifted value exceeds any DW-bit divisor.
    assign o_qbit = w_shift[DW] || (w_shift[DW-1:0] >= i_divisor);
    assign w_diff = w_shift[DW-1:0] - i_divisor;
    assign o_rem  = o_qbit ? w_diff : w_shift[DW-1:0];

endmodule

// File: rtl/unsigned_div_16by8_seq.sv
// Iterative 2*DW / DW unsigned restoring divider, one quotient bit per clock.
// Build option: UNSIGNED_DIV_APPROX_EN drops the low L quotient bits.
module unsigned_div_16by8_seq
    import unsigned_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int L  = L_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero
);

`ifdef UNSIGNED_DIV_APPROX_EN
    localparam bit APPROX = 1'b1;
`else
    localparam bit APPROX = 1'b0;
`endif

    localparam iter_cfg_t CFG = iter_count(DW, L, APPROX);
    localparam int ITER = CFG.iter;
    localparam int CW   = CFG.width;
    localparam int QSH  = APPROX ? L : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    div_state_t      r_state;
    div_state_t      w_next;
    logic [2*DW-1:0] r_work;
    logic [DW-1:0]   r_div;
    logic [DW-1:0]   r_rem;
    logic [CW-1:0]   r_cnt;
    logic            r_dbz;
    logic [2*DW-1:0] r_q_out;
    logic [DW-1:0]   r_r_out;
    logic            r_dbz_out;
    logic [DW-1:0]   w_rem_next;
    logic            w_qbit;
    logic [2*DW-1:0] w_work_next;

    div_restore_step #(
        .DW(DW)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_work[2*DW-1]),
        .i_divisor (r_div),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign w_work_next = {r_work[2*DW-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = CALC;
            end
            CALC: begin
                if (r_dbz || (r_cnt == '0)) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work    <= '0;
            r_div     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_dbz     <= 1'b0;
            r_q_out   <= '0;
            r_r_out   <= '0;
            r_dbz_out <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work <= dividend;
                        r_div  <= divisor;
                        r_rem  <= '0;
                        r_dbz  <= (divisor == '0);
                        r_cnt  <= (divisor == '0) ? '0 : CNT_LAST;
                    end
                end
                CALC: begin
                    // Zero divisor takes a single pass through CALC.
                    if (r_dbz) begin
                        r_q_out   <= '1;
                        r_r_out   <= r_work[DW-1:0];
                        r_dbz_out <= 1'b1;
                    end else begin
                        r_work <= w_work_next;
                        r_rem  <= w_rem_next;
                        r_cnt  <= r_cnt - CW'(1);
                        if (r_cnt == '0) begin
                            r_q_out   <= w_work_next << QSH;
                            r_r_out   <= w_rem_next;
                            r_dbz_out <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_q_out;
    assign remainder   = r_r_out;
    assign div_by_zero = r_dbz_out;

endmodule
